piso_serializer: RTL

Parametrised parallel-in/serial-out serializer with a valid/ready word interface, a one-word holding buffer and a bit-rate enable. It accepts WIDTH-bit words and shifts them out one bit per enabled cycle, MSB- or LSB-first. Frame-boundary flags are provided for downstream framing logic. Back-to-back words are emitted with no idle bit between them. The block sits between a word-oriented producer and a serial line driver or a downstream serial consumer.

---
 rtl/piso_serializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out serializer with a valid/ready word
// interface, a one-word holding buffer and a bit-rate enable (en).
// Words are emitted MSB- or LSB-first, back to back with no idle bit between
// them, and carry first/last framing flags.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to each frame.
// Without it, frames are WIDTH bits long.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             en,
    input  logic             abort,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_first,
    output logic             sdo_last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             sdo_q, sdo_d;
    logic             sdo_valid_q, sdo_valid_d;
    logic             sdo_first_q, sdo_first_d;
    logic             sdo_last_q, sdo_last_d;
    logic             busy_q, busy_d;
    logic             load;

    // Next-state logic: handshake into the hold register, frame sequencing,
    // then output decode from the next state so every output is a flop.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;

        if (abort) begin
            // Flush wins over load and over any handshake on this edge.
            state_d     = ST_IDLE;
            hold_full_d = 1'b0;
            cnt_d       = '0;
        end else begin
            // s_ready is ~hold_full_q, so a drain on this edge is not visible
            // to the producer until the next one.
            if (s_valid && !hold_full_q) begin
                hold_d      = s_data;
                hold_full_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // Start regardless of en so latency is one edge.
                    if (hold_full_q) load = 1'b1;
                end
                ST_SHIFT: begin
                    if (en) begin
                        if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                            state_d = ST_PARITY;
                            cnt_d   = CW'(WIDTH);
`else
                            if (hold_full_q) load = 1'b1;
                            else             state_d = ST_IDLE;
`endif
                        end else begin
                            shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (en) begin
                        if (hold_full_q) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase

            if (load) begin
                state_d     = ST_SHIFT;
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                cnt_d       = '0;
`ifdef PISO_PARITY_EN
                parity_d    = ^hold_q;
`endif
            end
        end

        sdo_valid_d = (state_d != ST_IDLE);
        sdo_d       = IDLE_LEVEL;
        sdo_first_d = 1'b0;
        sdo_last_d  = 1'b0;
        if (state_d == ST_SHIFT) begin
            sdo_d       = LSB_FIRST ? shift_d[0] : shift_d[WIDTH-1];
            sdo_first_d = (cnt_d == '0);
`ifndef PISO_PARITY_EN
            sdo_last_d  = (cnt_d == LAST_IDX);
`endif
        end
`ifdef PISO_PARITY_EN
        if (state_d == ST_PARITY) begin
            sdo_d      = parity_d;
            sdo_last_d = 1'b1;
        end
`endif
        busy_d = sdo_valid_d || hold_full_d;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
            sdo_q       <= IDLE_LEVEL;
            sdo_valid_q <= 1'b0;
            sdo_first_q <= 1'b0;
            sdo_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
            sdo_q       <= sdo_d;
            sdo_valid_q <= sdo_valid_d;
            sdo_first_q <= sdo_first_d;
            sdo_last_q  <= sdo_last_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = ~hold_full_q;
    assign sdo       = sdo_q;
    assign sdo_valid = sdo_valid_q;
    assign sdo_first = sdo_first_q;
    assign sdo_last  = sdo_last_q;
    assign busy      = busy_q;

endmodule
